program_loader: RTL

//  Boot-time program loader feeding the CPU's instruction-memory load port (instruction_in,

---
 rtl/loader_pkg.sv | 11 +
 rtl/program_loader_if.sv | 23 ++
 rtl/loader_checksum.sv | 24 ++
 rtl/program_loader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
`timescale 1ns/1ps
package loader_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_e;
endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory load port of the program loader.
`timescale 1ns/1ps
interface program_loader_if;
  import loader_pkg::*;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [WORD_W-1:0] instruction_in;
  logic [WORD_W-1:0] load_address;
  logic              load_instruction;
  logic              pc_reset;
  logic              done;
  logic              error;

  // Loader side.
  modport master (input byte_in, byte_valid,
                  output byte_ready, instruction_in, load_address, load_instruction,
                         pc_reset, done, error);
  // Stream source / CPU side.
  modport slave  (output byte_in, byte_valid,
                  input byte_ready, instruction_in, load_address, load_instruction,
                        pc_reset, done, error);
endinterface

// File: rtl/loader_checksum.sv
// 8-bit wrap-around accumulator with clear, add-on-strobe and compare.
`timescale 1ns/1ps
module loader_checksum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic [BYTE_W-1:0] cmp_i,
  output logic              match_o
);
  logic [BYTE_W-1:0] sum_q;

  // Clear wins over add so a SYNC restart always starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   sum_q <= '0;
    else if (clr_i) sum_q <= '0;
    else if (add_i) sum_q <= sum_q + data_i;
  end

  assign match_o = (sum_q == cmp_i);
endmodule

// File: rtl/program_loader.sv
// Boot loader: parses SYNC/count/words/checksum frames, writes words to
// instruction memory and releases the CPU only after a verified image.
`timescale 1ns/1ps
module program_loader
  import loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR      = 16'h0000,
  parameter logic [WORD_W-1:0] MAX_WORDS      = 16'd1024,
  parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int                TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  program_loader_if.master bus
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   cnt_hi_q, cnt_hi_d;
  logic [WORD_W-1:0]   rem_q, rem_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                ready_q, strobe_q, pcr_q, done_q, err_q;
  logic                xfer, timed, cs_clr, cs_add, cs_match;

  assign xfer  = bus.byte_valid && ready_q;
  // WRITE is excluded: the loader itself stalls the stream there.
  assign timed = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) || (state_q == S_W_HI) ||
                 (state_q == S_W_LO)   || (state_q == S_CSUM);

  loader_checksum u_csum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cs_clr),
    .add_i   (cs_add),
    .data_i  (bus.byte_in),
    .cmp_i   (bus.byte_in),
    .match_o (cs_match)
  );

  // Next-state and datapath updates; a SYNC is only a restart outside a frame.
  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    rem_d    = rem_q;
    word_d   = word_q;
    addr_d   = addr_q;
    idle_d   = '0;
    cs_clr   = 1'b0;
    cs_add   = 1'b0;
    if (timed && !xfer) idle_d = idle_q + IDLE_W'(1);
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (xfer && bus.byte_in == SYNC_BYTE) begin
          state_d = S_CNT_HI;
          cs_clr  = 1'b1;
          addr_d  = BASE_ADDR;
        end
      end
      S_CNT_HI: if (xfer) begin
        cnt_hi_d = bus.byte_in;
        cs_add   = 1'b1;
        state_d  = S_CNT_LO;
      end
      S_CNT_LO: if (xfer) begin
        cs_add = 1'b1;
        rem_d  = {cnt_hi_q, bus.byte_in};
        if (rem_d > MAX_WORDS) state_d = S_ERROR;
        else if (rem_d == '0)  state_d = S_CSUM;
        else                   state_d = S_W_HI;
      end
      S_W_HI: if (xfer) begin
        word_d[15:8] = bus.byte_in;
        cs_add       = 1'b1;
        state_d      = S_W_LO;
      end
      S_W_LO: if (xfer) begin
        word_d[7:0] = bus.byte_in;
        cs_add      = 1'b1;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        // Address/remaining advance on the edge leaving WRITE so both stay
        // stable while the strobe is high.
        addr_d  = addr_q + 16'd1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? S_CSUM : S_W_HI;
      end
      S_CSUM: if (xfer) state_d = cs_match ? S_DONE : S_ERROR;
      default: state_d = S_IDLE;
    endcase
    if (timed && !xfer && idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) state_d = S_ERROR;
  end

  // State, datapath and outputs; outputs are decoded from the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_hi_q <= '0;
      rem_q    <= '0;
      word_q   <= '0;
      addr_q   <= BASE_ADDR;
      idle_q   <= '0;
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
      pcr_q    <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_hi_q <= cnt_hi_d;
      rem_q    <= rem_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      idle_q   <= idle_d;
      ready_q  <= (state_d != S_WRITE);
      strobe_q <= (state_d == S_WRITE);
      pcr_q    <= (state_d != S_DONE);
      done_q   <= (state_d == S_DONE);
      err_q    <= (state_d == S_ERROR);
    end
  end

  assign bus.byte_ready       = ready_q;
  assign bus.instruction_in   = word_q;
  assign bus.load_address     = addr_q;
  assign bus.load_instruction = strobe_q;
  assign bus.pc_reset         = pcr_q;
  assign bus.done             = done_q;
  assign bus.error            = err_q;
endmodule
